// File: rtl/iso_lane_scrambler_if.sv
// Symbol bus between the ISO transport top and the lane scrambler.
// Index n of each packed array carries lane n.
interface iso_lane_scrambler_if;
  logic [3:0][7:0] iso_symbols;
  logic [3:0]      iso_control_sym_flag;
  logic [3:0][7:0] scr_symbols;
  logic [3:0]      scr_control_sym_flag;
  logic            scr_sr_inserted;

  modport master (
    output iso_symbols, iso_control_sym_flag,
    input  scr_symbols, scr_control_sym_flag, scr_sr_inserted
  );

  modport slave (
    input  iso_symbols, iso_control_sym_flag,
    output scr_symbols, scr_control_sym_flag, scr_sr_inserted
  );
endinterface

// File: rtl/iso_lane_scrambler.sv
// Per-lane DP scrambler with BS->SR substitution and optional transmit lane skew.
// Optional feature macro: ISO_LANE_SKEW_EN (lane n delayed by 2n extra cycles).
module iso_lane_scrambler (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spm_iso_start,
  input  logic                 spm_scr_bypass,
  input  logic [1:0]           td_lane_count,
  iso_lane_scrambler_if.slave  bus
);

  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  localparam logic [15:0] LFSR_TAPS = 16'h0039;
  localparam logic [7:0]  SYM_BS    = 8'hBC;
  localparam logic [7:0]  SYM_SR    = 8'h1C;
  localparam logic [8:0]  BS_LAST   = 9'd511;

  // Runs the Galois LFSR eight steps LSB-first; returns {next_state, keystream_byte}.
  function automatic logic [23:0] lfsr_step8(input logic [15:0] state);
    logic [15:0] s;
    logic [7:0]  ks;
    s  = state;
    ks = '0;
    for (int i = 0; i < 8; i++) begin
      ks[i] = s[15];
      s     = {s[14:0], 1'b0} ^ (s[15] ? LFSR_TAPS : 16'h0000);
    end
    return {s, ks};
  endfunction

  logic [15:0]     lfsr;
  logic [8:0]      bs_cnt;
  logic [15:0]     lfsr_adv;
  logic [7:0]      ks_byte;
  logic            is_bs;
  logic            is_sr_in;
  logic            sr_replace;
  logic [3:0]      lane_active;
  logic [3:0][7:0] stage_sym_d;
  logic [3:0]      stage_flag_d;
  logic [3:0][7:0] stage_sym;
  logic [3:0]      stage_flag;
  logic            sr_inserted;

  assign {lfsr_adv, ks_byte} = lfsr_step8(lfsr);

  // BS/SR detection looks at lane 0 only; the other lanes carry copies.
  assign is_bs      = bus.iso_control_sym_flag[0] && (bus.iso_symbols[0] == SYM_BS);
  assign is_sr_in   = bus.iso_control_sym_flag[0] && (bus.iso_symbols[0] == SYM_SR);
  assign sr_replace = is_bs && (bs_cnt == BS_LAST);

  always_comb begin
    case (td_lane_count)
      2'd0:    lane_active = 4'b0001;
      2'd1:    lane_active = 4'b0011;
      default: lane_active = 4'b1111;
    endcase
  end

  // NOTE: every output of a combinational block gets a default before any branch,
  // otherwise a missed path infers a latch.
  always_comb begin
    stage_sym_d  = '0;
    stage_flag_d = '0;
    if (spm_iso_start) begin
      for (int n = 0; n < 4; n++) begin
        if (lane_active[n]) begin
          if (sr_replace) begin
            stage_sym_d[n]  = SYM_SR;
            stage_flag_d[n] = 1'b1;
          end else if (bus.iso_control_sym_flag[n]) begin
            stage_sym_d[n]  = bus.iso_symbols[n];
            stage_flag_d[n] = 1'b1;
          end else begin
            stage_sym_d[n]  = spm_scr_bypass ? bus.iso_symbols[n]
                                             : (bus.iso_symbols[n] ^ ks_byte);
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr        <= LFSR_SEED;
      bs_cnt      <= '0;
      stage_sym   <= '0;
      stage_flag  <= '0;
      sr_inserted <= 1'b0;
    end else begin
      stage_sym   <= stage_sym_d;
      stage_flag  <= stage_flag_d;
      sr_inserted <= spm_iso_start && sr_replace;
      if (!spm_iso_start) begin
        lfsr   <= LFSR_SEED;
        bs_cnt <= '0;
      end else begin
        lfsr <= (sr_replace || is_sr_in) ? LFSR_SEED : lfsr_adv;
        if (is_bs) begin
          bs_cnt <= bs_cnt + 9'd1;  // 511 wraps to 0 on the replaced BS
        end
      end
    end
  end

  logic [7:0] out_sym  [4];
  logic       out_flag [4];

  assign out_sym[0]  = stage_sym[0];
  assign out_flag[0] = stage_flag[0];

`ifdef ISO_LANE_SKEW_EN
  for (genvar n = 1; n < 4; n++) begin : g_skew
    localparam int DEPTH = 2 * n;
    logic [DEPTH-1:0][7:0] sym_line;
    logic [DEPTH-1:0]      flag_line;

    // NOTE: the delay lines are reset like any other state so a reset leaves
    // every lane output at zero immediately, not after the line drains.
    always_ff @(posedge clk) begin
      if (rst) begin
        sym_line  <= '0;
        flag_line <= '0;
      end else begin
        sym_line  <= {sym_line[DEPTH-2:0], stage_sym[n]};
        flag_line <= {flag_line[DEPTH-2:0], stage_flag[n]};
      end
    end

    assign out_sym[n]  = sym_line[DEPTH-1];
    assign out_flag[n] = flag_line[DEPTH-1];
  end
`else
  for (genvar n = 1; n < 4; n++) begin : g_noskew
    assign out_sym[n]  = stage_sym[n];
    assign out_flag[n] = stage_flag[n];
  end
`endif

  assign bus.scr_symbols          = {out_sym[3], out_sym[2], out_sym[1], out_sym[0]};
  assign bus.scr_control_sym_flag = {out_flag[3], out_flag[2], out_flag[1], out_flag[0]};
  assign bus.scr_sr_inserted      = sr_inserted;

endmodule

// File: tb/tb_iso_lane_scrambler.sv
// Self-checking bench for iso_lane_scrambler: randomized and directed stimulus
// against a cycle-level reference model (honours ISO_LANE_SKEW_EN).
module tb_iso_lane_scrambler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       bypass;
  logic [1:0] lane_count;

  iso_lane_scrambler_if bus ();

  iso_lane_scrambler dut (
    .clk            (clk),
    .rst            (rst),
    .spm_iso_start  (start),
    .spm_scr_bypass (bypass),
    .td_lane_count  (lane_count),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Stimulus for the next cycle
  logic       in_rst;
  logic       in_start;
  logic       in_bypass;
  logic [1:0] in_count;
  logic [7:0] in_sym [4];
  logic [3:0] in_flag;

  // Reference model state
  int         m_lfsr;
  int         m_bs;
  logic [8:0] m_q [4][$];
  logic [8:0] exp_lane [4];
  logic       exp_sr;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int lane_delay(input int n);
`ifdef ISO_LANE_SKEW_EN
    return 2 * n;
`else
    return 0;
`endif
  endfunction

  // Keystream byte for state s (out bit = MSB, then shift and fold taps); returns next state.
  function automatic int lfsr_byte(input int s, output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      b[i] = (s >= 32768);
      s    = (s * 2) % 65536;
      if (b[i]) s = s ^ 'h39;
    end
    return s;
  endfunction

  function automatic void model_reset();
    m_lfsr = 'hFFFF;
    m_bs   = 0;
    exp_sr = 1'b0;
    for (int n = 0; n < 4; n++) begin
      m_q[n].delete();
      for (int d = 0; d < lane_delay(n); d++) m_q[n].push_back(9'h000);
      exp_lane[n] = 9'h000;
    end
  endfunction

  function automatic void model_cycle();
    logic [8:0] v [4];
    logic [7:0] ks;
    int         nxt;
    int         n_act;
    bit         bs, sr_in, sr_rep;
    exp_sr = 1'b0;
    for (int n = 0; n < 4; n++) v[n] = 9'h000;
    if (!in_start) begin
      m_lfsr = 'hFFFF;
      m_bs   = 0;
    end else begin
      nxt    = lfsr_byte(m_lfsr, ks);
      n_act  = (in_count == 2'd0) ? 1 : (in_count == 2'd1) ? 2 : 4;
      bs     = in_flag[0] && (in_sym[0] == 8'hBC);
      sr_in  = in_flag[0] && (in_sym[0] == 8'h1C);
      sr_rep = bs && (m_bs == 511);
      for (int n = 0; n < n_act; n++) begin
        if (sr_rep)          v[n] = {1'b1, 8'h1C};
        else if (in_flag[n]) v[n] = {1'b1, in_sym[n]};
        else                 v[n] = {1'b0, in_bypass ? in_sym[n] : (in_sym[n] ^ ks)};
      end
      exp_sr = sr_rep;
      m_lfsr = (sr_rep || sr_in) ? 'hFFFF : nxt;
      if (bs) m_bs = (m_bs + 1) % 512;
    end
    for (int n = 0; n < 4; n++) begin
      m_q[n].push_back(v[n]);
      exp_lane[n] = m_q[n].pop_front();
    end
  endfunction

  function automatic logic [36:0] exp_vec();
    logic [31:0] s;
    logic [3:0]  f;
    for (int n = 0; n < 4; n++) begin
      s[n*8 +: 8] = exp_lane[n][7:0];
      f[n]        = exp_lane[n][8];
    end
    return {exp_sr, f, s};
  endfunction

  function automatic logic [36:0] act_vec();
    return {bus.scr_sr_inserted, bus.scr_control_sym_flag, bus.scr_symbols};
  endfunction

  // Apply the staged inputs, advance the model, and settle at the following negedge.
  task automatic step();
    rst                      = in_rst;
    start                    = in_start;
    bypass                   = in_bypass;
    lane_count               = in_count;
    for (int n = 0; n < 4; n++) bus.iso_symbols[n] = in_sym[n];
    bus.iso_control_sym_flag = in_flag;
    if (in_rst) model_reset();
    else        model_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_all(input logic [7:0] sym, input logic flag);
    for (int n = 0; n < 4; n++) in_sym[n] = sym;
    in_flag = {4{flag}};
  endtask

  task automatic set_rand_data();
    for (int n = 0; n < 4; n++) in_sym[n] = 8'($urandom);
    in_flag = 4'b0000;
  endtask

  task automatic test_reset();
    in_rst = 1'b1; in_start = 1'b1; in_bypass = 1'b0; in_count = 2'd3;
    set_rand_data();
    for (int i = 0; i < 3; i++) begin
      step();
      if (act_vec() !== 37'h0) begin
        n_bad++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=%h", i, act_vec(), 37'h0);
      end
      n_cmp++;
    end
    in_rst = 1'b0;
  endtask

  task automatic test_keystream();
    in_start = 1'b1; in_bypass = 1'b0; in_count = 2'd3;
    set_all(8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i < 2 && bus.scr_symbols[0] !== (i == 0 ? 8'hFF : 8'h17)) begin
        n_bad++;
        $display("FAIL keystream_seed cyc=%0d got=%h want=%h", i, bus.scr_symbols[0],
                 (i == 0 ? 8'hFF : 8'h17));
      end
      if (i < 2) n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL keystream cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_bypass();
    in_start = 1'b1; in_bypass = 1'b1; in_count = 2'd3;
    set_all(8'hA5, 1'b0);
    step();
    if ({bus.scr_control_sym_flag[0], bus.scr_symbols[0]} !== 9'h0A5) begin
      n_bad++;
      $display("FAIL bypass_data got=%h want=%h", {bus.scr_control_sym_flag[0], bus.scr_symbols[0]}, 9'h0A5);
    end
    n_cmp++;
    set_all(8'hFB, 1'b1);
    step();
    if ({bus.scr_control_sym_flag[0], bus.scr_symbols[0]} !== 9'h1FB) begin
      n_bad++;
      $display("FAIL control_pass got=%h want=%h", {bus.scr_control_sym_flag[0], bus.scr_symbols[0]}, 9'h1FB);
    end
    n_cmp++;
    in_bypass = 1'b0;
    for (int i = 0; i < 12; i++) begin
      set_rand_data();
      step();
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL bypass_resume cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_lane_masking();
    in_start = 1'b1; in_bypass = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_count = 2'(c);
      for (int i = 0; i < 10; i++) begin
        if (c == 1) set_all(8'h55, 1'b0);
        else        set_rand_data();
        step();
        if (act_vec() !== exp_vec()) begin
          n_bad++;
          $display("FAIL lane_mask cnt=%0d cyc=%0d got=%h want=%h", c, i, act_vec(), exp_vec());
        end
        n_cmp++;
      end
      if (c == 1 && {bus.scr_control_sym_flag[3:2], bus.scr_symbols[3], bus.scr_symbols[2]} !== 18'h0) begin
        n_bad++;
        $display("FAIL lane_mask_idle got=%h want=%h",
                 {bus.scr_control_sym_flag[3:2], bus.scr_symbols[3], bus.scr_symbols[2]}, 18'h0);
      end
      if (c == 1) n_cmp++;
    end
  endtask

  task automatic test_sr_insertion();
    in_count = 2'd3; in_bypass = 1'b0;
    in_start = 1'b0; set_rand_data(); step();
    in_start = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      set_all(8'hBC, 1'b1);
      in_bypass = (k == 512);  // SR must still win over bypass
      step();
      in_bypass = 1'b0;
      if ({bus.scr_sr_inserted, bus.scr_control_sym_flag[0], bus.scr_symbols[0]} !==
          (k == 512 ? 10'h31C : 10'h1BC)) begin
        n_bad++;
        $display("FAIL sr_bs k=%0d got=%h want=%h", k,
                 {bus.scr_sr_inserted, bus.scr_control_sym_flag[0], bus.scr_symbols[0]},
                 (k == 512 ? 10'h31C : 10'h1BC));
      end
      n_cmp++;
      if (k == 512) set_all(8'h00, 1'b0);
      else          set_rand_data();
      step();
      if (k == 512 && bus.scr_symbols[0] !== 8'hFF) begin
        n_bad++;
        $display("FAIL sr_reseed got=%h want=%h", bus.scr_symbols[0], 8'hFF);
      end
      if (k == 512) n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL sr_stream k=%0d got=%h want=%h", k, act_vec(), exp_vec());
      end
      n_cmp++;
    end
    for (int i = 0; i < 8; i++) begin
      set_rand_data();
      step();
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL sr_skew_tail cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_midstream();
    in_start = 1'b1; in_bypass = 1'b0; in_count = 2'd3;
    for (int i = 0; i < 100; i++) begin
      set_rand_data();
      step();
    end
    in_rst = 1'b1;
    step();
    if (act_vec() !== 37'h0) begin
      n_bad++;
      $display("FAIL midstream_reset got=%h want=%h", act_vec(), 37'h0);
    end
    n_cmp++;
    in_rst = 1'b0;
    set_all(8'h00, 1'b0);
    step();
    if (bus.scr_symbols[0] !== 8'hFF) begin
      n_bad++;
      $display("FAIL midstream_restart got=%h want=%h", bus.scr_symbols[0], 8'hFF);
    end
    n_cmp++;
  endtask

  task automatic test_stream_stop();
    in_start = 1'b1; in_bypass = 1'b0; in_count = 2'd3;
    for (int k = 0; k < 300; k++) begin
      set_all(8'hBC, 1'b1); step();
      set_rand_data();      step();
    end
    in_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand_data();
      step();
      if ({bus.scr_sr_inserted, bus.scr_control_sym_flag[0], bus.scr_symbols[0]} !== 10'h0 ||
          act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL stop_idle cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      n_cmp++;
    end
    in_start = 1'b1;
    set_all(8'h00, 1'b0);
    step();
    if (bus.scr_symbols[0] !== 8'hFF) begin
      n_bad++;
      $display("FAIL stop_restart got=%h want=%h", bus.scr_symbols[0], 8'hFF);
    end
    n_cmp++;
    for (int k = 1; k <= 512; k++) begin
      set_all(8'hBC, 1'b1);
      step();
      if (bus.scr_sr_inserted !== (k == 512)) begin
        n_bad++;
        $display("FAIL stop_bs_count k=%0d got=%b want=%b", k, bus.scr_sr_inserted, (k == 512));
      end
      n_cmp++;
      set_rand_data();
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_start  = ($urandom_range(0, 19) != 0);
      in_bypass = ($urandom_range(0, 3) == 0);
      in_count  = 2'($urandom_range(0, 3));
      for (int n = 0; n < 4; n++) begin
        in_sym[n]  = 8'($urandom);
        in_flag[n] = ($urandom_range(0, 3) == 0);
      end
      case ($urandom_range(0, 9))
        0: begin in_sym[0] = 8'hBC; in_flag[0] = 1'b1; end
        1: begin in_sym[0] = 8'h1C; in_flag[0] = 1'b1; end
        default: ;
      endcase
      step();
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      n_cmp++;
    end
  endtask

  initial begin
    in_rst = 1'b1; in_start = 1'b0; in_bypass = 1'b0; in_count = 2'd3;
    set_all(8'h00, 1'b0);
    model_reset();
    test_reset();
    test_keystream();
    test_bypass();
    test_lane_masking();
    test_sr_insertion();
    test_reset_midstream();
    test_stream_stop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
